// File: rtl/mem_stage_ws.sv
// Memory pipeline stage with a fixed number of wait states.
// Good loads/stores stall upstream for WAIT_CYCLES cycles and then complete.
// Misaligned or out-of-range accesses finish at once with a fault pulse.
// The data store is four byte-lane arrays, so stores can write single lanes.
module mem_stage_ws #(
  parameter int          DEPTH_LOG2  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int          WAIT_CYCLES = 2,
  parameter int          DEST_W      = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic [1:0]        size_in,
  input  logic              sign_in,
  input  logic [DEST_W-1:0] dest_in,
  input  logic [31:0]       alu_result_in,
  input  logic [31:0]       store_data_in,
  output logic              freeze,
  output logic              wb_en,
  output logic              mem_r_en,
  output logic [DEST_W-1:0] dest,
  output logic [31:0]       alu_result,
  output logic [31:0]       mem_data,
  output logic              fault
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [3:0]          r_cnt;
  logic [3:0]          w_cnt_next;
  logic                w_freeze;
  logic                w_capture;

  logic                r_wb_en;
  logic                r_mem_r_en;
  logic [DEST_W-1:0]   r_dest;
  logic [31:0]         r_alu_result;
  logic [31:0]         r_mem_data;
  logic                r_fault;

  logic [31:0]         w_offset;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic                w_in_range;
  logic                w_misalign;
  logic                w_access;
  logic                w_bad;
  logic                w_good;
  logic                w_load;
  logic                w_we;
  logic [3:0]          w_be;
  logic [31:0]         w_wdata;
  logic [31:0]         w_rd_word;
  logic [31:0]         w_shifted;
  logic [31:0]         w_ld_ext;

  // Address decode: offset from base, word index and access legality.
  assign w_offset   = alu_result_in - BASE_ADDR;
  assign w_idx      = w_offset[DEPTH_LOG2+1:2];
  assign w_in_range = {1'b0, w_offset} < (33'd1 << (DEPTH_LOG2 + 2));
  assign w_misalign = ((size_in == 2'b01) && w_offset[0]) ||
                      (size_in[1] && (w_offset[1:0] != 2'b00));
  assign w_access   = mem_r_en_in | mem_w_en_in;
  assign w_bad      = w_access & (w_misalign | ~w_in_range);
  assign w_good     = w_access & ~w_bad;
  // A simultaneous read and write request behaves as a store.
  assign w_load     = mem_r_en_in & ~mem_w_en_in;

  // The upstream stall must never be seen while reset is held.
  assign freeze = w_freeze & ~rst;

  // Reset aborts any pending access, so the write is gated by rst too.
  assign w_we = w_capture & w_good & mem_w_en_in & ~rst;

  // State register for the wait-state sequencer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next state, stall and capture decision.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_freeze     = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_good && (WAIT_CYCLES != 0)) begin
          w_freeze     = 1'b1;
          w_state_next = S_WAIT;
          w_cnt_next   = CNT_INIT;
        end else begin
          w_capture = 1'b1;
        end
      end
      S_WAIT: begin
        if (r_cnt != 4'd0) begin
          w_freeze   = 1'b1;
          w_cnt_next = r_cnt - 4'd1;
        end else begin
          w_capture    = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Store lane enables and lane-replicated write data (little-endian).
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = store_data_in;
    case (size_in)
      2'b00: begin
        w_be    = 4'b0001 << w_offset[1:0];
        w_wdata = {4{store_data_in[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << {w_offset[1], 1'b0};
        w_wdata = {2{store_data_in[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = store_data_in;
      end
    endcase
  end

  // One byte-wide array per lane; reads return pre-write contents.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] r_lane [0:DEPTH-1];

      // Lane write on a completing good store.
      always_ff @(posedge clk) begin
        if (w_we && w_be[gi]) begin
          r_lane[w_idx] <= w_wdata[gi*8 +: 8];
        end
      end

      assign w_rd_word[gi*8 +: 8] = r_lane[w_idx];
    end
  endgenerate

  // Right-align the addressed lanes and extend to 32 bits.
  always_comb begin
    w_shifted = w_rd_word >> {w_offset[1:0], 3'b000};
    w_ld_ext  = w_shifted;
    case (size_in)
      2'b00:   w_ld_ext = sign_in ? {{24{w_shifted[7]}}, w_shifted[7:0]}
                                  : {24'd0, w_shifted[7:0]};
      2'b01:   w_ld_ext = sign_in ? {{16{w_shifted[15]}}, w_shifted[15:0]}
                                  : {16'd0, w_shifted[15:0]};
      default: w_ld_ext = w_rd_word;
    endcase
  end

  // Output register: capture the instruction when it completes, else a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb_en      <= 1'b0;
      r_mem_r_en   <= 1'b0;
      r_dest       <= '0;
      r_alu_result <= 32'd0;
      r_mem_data   <= 32'd0;
      r_fault      <= 1'b0;
    end else if (w_capture) begin
      r_wb_en      <= wb_en_in & ~w_bad;
      r_mem_r_en   <= w_load & w_good;
      r_dest       <= dest_in;
      r_alu_result <= alu_result_in;
      r_mem_data   <= (w_load & w_good) ? w_ld_ext : 32'd0;
      r_fault      <= w_bad;
    end else begin
      r_wb_en      <= 1'b0;
      r_mem_r_en   <= 1'b0;
      r_dest       <= '0;
      r_alu_result <= 32'd0;
      r_mem_data   <= 32'd0;
      r_fault      <= 1'b0;
    end
  end

  assign wb_en      = r_wb_en;
  assign mem_r_en   = r_mem_r_en;
  assign dest       = r_dest;
  assign alu_result = r_alu_result;
  assign mem_data   = r_mem_data;
  assign fault      = r_fault;

endmodule

// File: tb/tb_mem_stage_ws.sv
// Bench for mem_stage_ws: a WAIT_CYCLES=2 instance driven through a byte-level
// reference memory and scoreboard, plus a WAIT_CYCLES=0 instance for back-to-back use.
module tb_mem_stage_ws;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Wait-state instance signals.
  logic        wb_en_in, mem_r_en_in, mem_w_en_in, sign_in;
  logic [1:0]  size_in;
  logic [4:0]  dest_in;
  logic [31:0] alu_result_in, store_data_in;
  logic        freeze, wb_en, mem_r_en, fault;
  logic [4:0]  dest;
  logic [31:0] alu_result, mem_data;

  // Zero-wait instance signals.
  logic        b_wb_en_in, b_mem_r_en_in, b_mem_w_en_in, b_sign_in;
  logic [1:0]  b_size_in;
  logic [4:0]  b_dest_in;
  logic [31:0] b_alu_result_in, b_store_data_in;
  logic        b_freeze, b_wb_en, b_mem_r_en, b_fault;
  logic [4:0]  b_dest;
  logic [31:0] b_alu_result, b_mem_data;

  mem_stage_ws #(.DEPTH_LOG2(10), .BASE_ADDR(32'd1024), .WAIT_CYCLES(2), .DEST_W(5)) u_dut (
    .clk(clk), .rst(rst),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
    .size_in(size_in), .sign_in(sign_in), .dest_in(dest_in),
    .alu_result_in(alu_result_in), .store_data_in(store_data_in),
    .freeze(freeze), .wb_en(wb_en), .mem_r_en(mem_r_en), .dest(dest),
    .alu_result(alu_result), .mem_data(mem_data), .fault(fault)
  );

  mem_stage_ws #(.DEPTH_LOG2(10), .BASE_ADDR(32'd1024), .WAIT_CYCLES(0), .DEST_W(5)) u_dut0 (
    .clk(clk), .rst(rst),
    .wb_en_in(b_wb_en_in), .mem_r_en_in(b_mem_r_en_in), .mem_w_en_in(b_mem_w_en_in),
    .size_in(b_size_in), .sign_in(b_sign_in), .dest_in(b_dest_in),
    .alu_result_in(b_alu_result_in), .store_data_in(b_store_data_in),
    .freeze(b_freeze), .wb_en(b_wb_en), .mem_r_en(b_mem_r_en), .dest(b_dest),
    .alu_result(b_alu_result), .mem_data(b_mem_data), .fault(b_fault)
  );

  typedef struct packed {
    logic        we;
    logic        re;
    logic        wb;
    logic [1:0]  sz;
    logic        sg;
    logic [4:0]  d;
    logic [31:0] a;
    logic [31:0] sd;
  } op_t;

  typedef struct packed {
    logic        wb_en;
    logic        mem_r_en;
    logic [4:0]  dest;
    logic [31:0] alu;
    logic [31:0] data;
    logic        fault;
    logic [3:0]  nfrz;
    logic        bub_ok;
  } res_t;

  res_t       sb_q[$];
  res_t       b_q[$];
  logic [7:0] mdl [int unsigned];
  int         checks = 0;
  int         errors = 0;

  function automatic op_t mk(input logic we, input logic re, input logic wb,
                             input logic [1:0] sz, input logic sg, input logic [4:0] d,
                             input logic [31:0] a, input logic [31:0] sd);
    op_t o;
    o.we = we; o.re = re; o.wb = wb; o.sz = sz; o.sg = sg; o.d = d; o.a = a; o.sd = sd;
    return o;
  endfunction

  function automatic logic [7:0] mrd(input int unsigned ba);
    return mdl.exists(ba) ? mdl[ba] : 8'h00;
  endfunction

  // Reference behaviour for the 2-wait instance; also updates the model memory.
  function automatic res_t model(input op_t o);
    res_t        r;
    logic [31:0] off;
    logic [31:0] lw;
    bit          inr, mis, acc, bad, ld;
    int          nb;
    off = o.a - 32'd1024;
    inr = off < 32'd4096;
    mis = (o.sz == 2'b01 && off[0]) || (o.sz[1] && off[1:0] != 2'b00);
    acc = o.we || o.re;
    bad = acc && (mis || !inr);
    ld  = o.re && !o.we && !bad;
    nb  = (o.sz == 2'b00) ? 1 : (o.sz == 2'b01) ? 2 : 4;
    lw  = 32'd0;
    for (int k = 0; k < nb; k++) lw[8*k +: 8] = mrd(o.a + k);
    if (o.sg && nb == 1 && lw[7])  lw[31:8]  = 24'hFFFFFF;
    if (o.sg && nb == 2 && lw[15]) lw[31:16] = 16'hFFFF;
    r.wb_en    = o.wb && !bad;
    r.mem_r_en = ld;
    r.dest     = o.d;
    r.alu      = o.a;
    r.data     = ld ? lw : 32'd0;
    r.fault    = bad;
    r.nfrz     = (acc && !bad) ? 4'd2 : 4'd0;
    r.bub_ok   = 1'b1;
    if (o.we && !bad) for (int k = 0; k < nb; k++) mdl[o.a + k] = o.sd[8*k +: 8];
    return r;
  endfunction

  task automatic drive_idle();
    wb_en_in = 0; mem_r_en_in = 0; mem_w_en_in = 0; size_in = 0; sign_in = 0;
    dest_in = 0; alu_result_in = 0; store_data_in = 0;
  endtask

  // Present one instruction (entered just after a falling edge), hold it through
  // the stall, record freeze cycles and bubble outputs, return the captured result.
  task automatic issue(input op_t o, output res_t obs);
    int guard;
    wb_en_in = o.wb; mem_r_en_in = o.re; mem_w_en_in = o.we; size_in = o.sz;
    sign_in = o.sg; dest_in = o.d; alu_result_in = o.a; store_data_in = o.sd;
    sb_q.push_back(model(o));
    obs = '0;
    obs.bub_ok = 1'b1;
    guard = 0;
    #1;
    while (freeze === 1'b1 && guard < 14) begin
      obs.nfrz = obs.nfrz + 4'd1;
      @(negedge clk); #1;
      guard++;
      if (wb_en !== 1'b0 || mem_r_en !== 1'b0 || fault !== 1'b0 ||
          dest !== 5'd0 || alu_result !== 32'd0 || mem_data !== 32'd0)
        obs.bub_ok = 1'b0;
    end
    @(posedge clk); #1;
    obs.wb_en = wb_en; obs.mem_r_en = mem_r_en; obs.dest = dest;
    obs.alu = alu_result; obs.data = mem_data; obs.fault = fault;
    $display("txn we=%0b re=%0b sz=%0d sg=%0b addr=%h sd=%h -> wb=%0b rd=%0b dest=%0d alu=%h data=%h fault=%0b frz=%0d",
             o.we, o.re, o.sz, o.sg, o.a, o.sd, wb_en, mem_r_en, dest, alu_result, mem_data, fault, obs.nfrz);
    drive_idle();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    mem_w_en_in = 1'b1; size_in = 2'b10; alu_result_in = 32'd1024; store_data_in = 32'h12345678;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if (freeze !== 1'b0) begin errors++; $display("FAIL reset_freeze: got %b want 0", freeze); end
    checks++;
    if ({wb_en, mem_r_en, dest, alu_result, mem_data, fault} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got wb=%b rd=%b dest=%h alu=%h data=%h fault=%b want all 0",
               wb_en, mem_r_en, dest, alu_result, mem_data, fault);
    end
    checks++;
    if ({b_freeze, b_wb_en, b_mem_r_en, b_dest, b_alu_result, b_mem_data, b_fault} !== '0) begin
      errors++; $display("FAIL reset_outputs0: zero-wait instance not cleared");
    end
    drive_idle();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_word();
    op_t  ops[$];
    res_t obs, e;
    ops.push_back(mk(1, 0, 0, 2'b10, 0, 5'd0, 32'd1024, 32'hDEADBEEF));
    ops.push_back(mk(0, 1, 1, 2'b10, 0, 5'd3, 32'd1024, 32'd0));
    ops.push_back(mk(1, 0, 0, 2'b10, 0, 5'd0, 32'd5116, 32'h0F1E2D3C));
    ops.push_back(mk(0, 1, 1, 2'b11, 1, 5'd4, 32'd5116, 32'd0));
    foreach (ops[i]) begin
      issue(ops[i], obs);
      e = sb_q.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL word[%0d]: got %h want %h", i, obs, e); end
      if (i == 1) begin
        checks++;
        if (obs.data !== 32'hDEADBEEF || obs.mem_r_en !== 1'b1)
          begin errors++; $display("FAIL word_load: got %h rd=%b want deadbeef rd=1", obs.data, obs.mem_r_en); end
      end
    end
  endtask

  task automatic test_byte_sign();
    op_t  ops[$];
    res_t obs, e;
    logic [31:0] want[$];
    ops.push_back(mk(1, 0, 0, 2'b10, 0, 5'd0, 32'd1028, 32'h00000000)); want.push_back(32'h0);
    ops.push_back(mk(1, 0, 0, 2'b00, 0, 5'd0, 32'd1029, 32'h12345680)); want.push_back(32'h0);
    ops.push_back(mk(0, 1, 1, 2'b00, 1, 5'd1, 32'd1029, 32'd0));        want.push_back(32'hFFFFFF80);
    ops.push_back(mk(0, 1, 1, 2'b00, 0, 5'd2, 32'd1029, 32'd0));        want.push_back(32'h00000080);
    ops.push_back(mk(0, 1, 1, 2'b10, 1, 5'd3, 32'd1028, 32'd0));        want.push_back(32'h00008000);
    ops.push_back(mk(1, 0, 0, 2'b01, 0, 5'd0, 32'd1030, 32'h7777BEEF)); want.push_back(32'h0);
    ops.push_back(mk(0, 1, 1, 2'b01, 1, 5'd5, 32'd1030, 32'd0));        want.push_back(32'hFFFFBEEF);
    ops.push_back(mk(0, 1, 1, 2'b01, 0, 5'd6, 32'd1030, 32'd0));        want.push_back(32'h0000BEEF);
    ops.push_back(mk(0, 1, 1, 2'b10, 0, 5'd7, 32'd1028, 32'd0));        want.push_back(32'hBEEF8000);
    foreach (ops[i]) begin
      issue(ops[i], obs);
      e = sb_q.pop_front();
      checks++;
      if (obs !== e || obs.data !== want[i])
        begin errors++; $display("FAIL byte_sign[%0d]: got %h data=%h want %h data=%h", i, obs, obs.data, e, want[i]); end
    end
  endtask

  task automatic test_fault();
    op_t  ops[$];
    res_t obs, e;
    ops.push_back(mk(0, 1, 1, 2'b01, 1, 5'd8,  32'd1027, 32'd0));
    ops.push_back(mk(0, 1, 1, 2'b10, 0, 5'd9,  32'd1020, 32'd0));
    ops.push_back(mk(1, 0, 1, 2'b00, 0, 5'd10, 32'd1020, 32'h00000099));
    ops.push_back(mk(1, 0, 0, 2'b10, 0, 5'd11, 32'd1026, 32'h55555555));
    ops.push_back(mk(1, 0, 0, 2'b10, 0, 5'd12, 32'd5120, 32'h66666666));
    ops.push_back(mk(0, 1, 1, 2'b10, 0, 5'd13, 32'd1024, 32'd0));
    foreach (ops[i]) begin
      issue(ops[i], obs);
      e = sb_q.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL fault[%0d]: got %h want %h", i, obs, e); end
      if (i < 5) begin
        checks++;
        if (obs.fault !== 1'b1 || obs.nfrz !== 4'd0 || obs.wb_en !== 1'b0)
          begin errors++; $display("FAIL fault_pulse[%0d]: got fault=%b frz=%0d wb=%b want 1 0 0", i, obs.fault, obs.nfrz, obs.wb_en); end
      end
    end
    // The following idle cycle must drop the fault pulse.
    #1;
    checks++;
    if (fault !== 1'b0) begin errors++; $display("FAIL fault_clear: got %b want 0", fault); end
  endtask

  task automatic test_alu_pass();
    op_t  ops[$];
    res_t obs, e;
    ops.push_back(mk(0, 0, 1, 2'b10, 0, 5'd7,  32'h00000055, 32'hAAAAAAAA));
    ops.push_back(mk(0, 0, 0, 2'b00, 1, 5'd31, 32'hFFFFFFFF, 32'd0));
    ops.push_back(mk(0, 0, 1, 2'b01, 0, 5'd17, 32'd1027,     32'd0));
    ops.push_back(mk(1, 1, 1, 2'b10, 0, 5'd18, 32'd1032,     32'hA5A5A5A5));
    ops.push_back(mk(0, 1, 1, 2'b10, 0, 5'd19, 32'd1032,     32'd0));
    foreach (ops[i]) begin
      issue(ops[i], obs);
      e = sb_q.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL alu_pass[%0d]: got %h want %h", i, obs, e); end
    end
  endtask

  task automatic test_reset_abort();
    res_t obs, e;
    issue(mk(1, 0, 0, 2'b10, 0, 5'd0, 32'd1040, 32'h11223344), obs);
    e = sb_q.pop_front();
    checks++;
    if (obs !== e) begin errors++; $display("FAIL abort_setup: got %h want %h", obs, e); end
    wb_en_in = 1'b1; mem_w_en_in = 1'b1; size_in = 2'b10; dest_in = 5'd21;
    alu_result_in = 32'd1040; store_data_in = 32'hCAFEBABE;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (freeze !== 1'b0) begin errors++; $display("FAIL abort_freeze: got %b want 0", freeze); end
    @(posedge clk); #1;
    checks++;
    if ({wb_en, mem_r_en, dest, alu_result, mem_data, fault} !== '0) begin
      errors++;
      $display("FAIL abort_outputs: got wb=%b dest=%h alu=%h want all 0", wb_en, dest, alu_result);
    end
    drive_idle();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(mk(0, 1, 1, 2'b10, 0, 5'd22, 32'd1040, 32'd0), obs);
    e = sb_q.pop_front();
    checks++;
    if (obs !== e || obs.data !== 32'h11223344)
      begin errors++; $display("FAIL abort_unchanged: got %h data=%h want %h data=11223344", obs, obs.data, e); end
  endtask

  task automatic test_back_to_back();
    op_t  ops[$];
    res_t obs, e;
    res_t x;
    ops.push_back(mk(1, 0, 0, 2'b10, 0, 5'd0,  32'd1100, 32'h0BADF00D));
    ops.push_back(mk(0, 1, 1, 2'b10, 0, 5'd9,  32'd1100, 32'd0));
    ops.push_back(mk(1, 0, 0, 2'b00, 0, 5'd0,  32'd1101, 32'h000000EE));
    ops.push_back(mk(0, 1, 1, 2'b00, 1, 5'd10, 32'd1101, 32'd0));
    ops.push_back(mk(0, 1, 1, 2'b10, 0, 5'd11, 32'd1100, 32'd0));
    x = '0; x.bub_ok = 1'b1;
    x.alu = 32'd1100; b_q.push_back(x);
    x.wb_en = 1; x.mem_r_en = 1; x.dest = 9; x.data = 32'h0BADF00D; b_q.push_back(x);
    x = '0; x.bub_ok = 1'b1; x.alu = 32'd1101; b_q.push_back(x);
    x.wb_en = 1; x.mem_r_en = 1; x.dest = 10; x.data = 32'hFFFFFFEE; b_q.push_back(x);
    x.alu = 32'd1100; x.dest = 11; x.data = 32'h0BADEE0D; b_q.push_back(x);
    for (int c = 0; c <= ops.size(); c++) begin
      if (c < ops.size()) begin
        b_wb_en_in = ops[c].wb; b_mem_r_en_in = ops[c].re; b_mem_w_en_in = ops[c].we;
        b_size_in = ops[c].sz; b_sign_in = ops[c].sg; b_dest_in = ops[c].d;
        b_alu_result_in = ops[c].a; b_store_data_in = ops[c].sd;
      end else begin
        b_wb_en_in = 0; b_mem_r_en_in = 0; b_mem_w_en_in = 0; b_size_in = 0;
        b_sign_in = 0; b_dest_in = 0; b_alu_result_in = 0; b_store_data_in = 0;
      end
      #1;
      checks++;
      if (b_freeze !== 1'b0) begin errors++; $display("FAIL b2b_freeze[%0d]: got %b want 0", c, b_freeze); end
      if (c > 0) begin
        obs = '0; obs.bub_ok = 1'b1;
        obs.wb_en = b_wb_en; obs.mem_r_en = b_mem_r_en; obs.dest = b_dest;
        obs.alu = b_alu_result; obs.data = b_mem_data; obs.fault = b_fault;
        e = b_q.pop_front();
        $display("txn0 cyc=%0d -> wb=%0b rd=%0b dest=%0d alu=%h data=%h fault=%0b",
                 c, b_wb_en, b_mem_r_en, b_dest, b_alu_result, b_mem_data, b_fault);
        checks++;
        if (obs !== e) begin errors++; $display("FAIL b2b[%0d]: got %h want %h", c - 1, obs, e); end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    b_wb_en_in = 0; b_mem_r_en_in = 0; b_mem_w_en_in = 0; b_size_in = 0;
    b_sign_in = 0; b_dest_in = 0; b_alu_result_in = 0; b_store_data_in = 0;
    @(negedge clk);
    test_reset();
    test_word();
    test_byte_sign();
    test_fault();
    test_alu_pass();
    test_reset_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_stage_ws.md
MEM_STAGE_WS -- requirements
Module: mem_stage_ws

Interface
REQ-001 Parameters SHALL be: DEPTH_LOG2, default 10, word count = 2^DEPTH_LOG2; BASE_ADDR, default 1024, byte address of word 0; WAIT_CYCLES, default 2, range 0..15, extra access cycles; DEST_W, default 5, destination register index width.
REQ-002 Ports SHALL be, name direction width meaning:
- clk input 1, single clock; all state updates on rising edge.
- rst input 1, reset, synchronous and active-high.
- wb_en_in input 1, writeback enable from EXE.
- mem_r_en_in input 1, load request.
- mem_w_en_in input 1, store request.
- size_in input 2: 00 byte, 01 half, 10 word, 11 treated as word.
- sign_in input 1: 1 sign-extends byte/half loads, 0 zero-extends.
- dest_in input DEST_W, destination register.
- alu_result_in input 32, ALU result and memory byte address.
- store_data_in input 32, store data, right-aligned.
- freeze output 1, combinational stall to upstream stages.
- wb_en output 1, registered writeback enable.
- mem_r_en output 1, registered load flag.
- dest output DEST_W, registered destination.
- alu_result output 32, registered ALU result.
- mem_data output 32, registered extended load data.
- fault output 1, registered one-cycle misaligned/out-of-range pulse.

Function
REQ-003 Offset SHALL be alu_result_in - BASE_ADDR (32-bit wrap); word index SHALL be offset[DEPTH_LOG2+1:2]; in range iff offset < 4*2^DEPTH_LOG2.
REQ-004 Access = mem_r_en_in | mem_w_en_in; both set SHALL act as store, mem_r_en output 0.
REQ-005 Misaligned: half with offset[0]=1; word with offset[1:0]!=0.
REQ-006 Bad access (misaligned or out of range) SHALL not stall or write; at next edge fault=1, wb_en=0, mem_r_en=0, mem_data=0.
REQ-007 FSM states SHALL be IDLE and WAIT, plus a 4-bit down-counter cnt.
REQ-008 IDLE, no access or bad access, or WAIT_CYCLES=0: freeze=0; output register captures inputs at next edge; state stays IDLE.
REQ-009 IDLE, good access, WAIT_CYCLES>0: freeze=1; next state WAIT with cnt=WAIT_CYCLES-1; output register loads bubble (wb_en=0, mem_r_en=0, dest=0, alu_result=0, mem_data=0, fault=0).
REQ-010 WAIT, cnt!=0: freeze=1; cnt decrements; bubble loaded.
REQ-011 WAIT, cnt=0: freeze=0; memory operation completes at this edge; output register captures inputs plus load data; state returns to IDLE.
REQ-012 Upstream SHALL hold all inputs stable while freeze=1; the block samples addresses and data only in the completing cycle.
REQ-013 Good access latency SHALL be WAIT_CYCLES+1 cycles from presentation to output register update; freeze high exactly WAIT_CYCLES cycles.
REQ-014 Store SHALL write little-endian byte lanes: byte to lane offset[1:0] from store_data_in[7:0]; half to lanes {offset[1],0}+1:{offset[1],0} from store_data_in[15:0]; word to all lanes; other lanes unchanged.
REQ-015 Load SHALL select the addressed lane(s), shift right-aligned, and sign- or zero-extend per sign_in; word ignores sign_in.
REQ-016 Load data SHALL reflect memory contents before any store in the same completing cycle.
REQ-017 Non-access instructions SHALL pass wb_en_in, dest_in, alu_result_in unchanged with one-cycle latency; mem_data=0.

Reset
REQ-018 rst=1 at an edge SHALL set state IDLE, cnt=0, and all registered outputs to 0; freeze SHALL read 0 while rst=1.
REQ-019 Reset during WAIT SHALL abort the access; no memory write occurs.
REQ-020 Memory contents SHALL not be cleared by rst; simulation initial contents are all zero.

Verification
REQ-021 WAIT_CYCLES=2, store word 0xDEADBEEF to 1024 -> freeze high 2 cycles, word 0 written on 3rd edge; load 1024 -> mem_data=0xDEADBEEF after 3 edges, mem_r_en=1.
REQ-022 Store byte 0x80 to 1029, then load byte 1029 with sign_in=1 -> 0xFFFFFF80; sign_in=0 -> 0x00000080; word at 1028 reads 0x00008000.
REQ-023 Load half at 1027 -> no freeze, next cycle fault=1, wb_en=0, memory unchanged; address 1020 -> same fault response.
REQ-024 ALU op wb_en_in=1, dest_in=7, alu_result_in=0x55 while idle -> next cycle wb_en=1, dest=7, alu_result=0x55, no freeze.
REQ-025 Store issued, rst=1 on 2nd WAIT cycle -> outputs 0, state IDLE, target word unchanged.
REQ-026 WAIT_CYCLES=0 build: back-to-back store then load same address -> freeze never asserts, load returns stored value one cycle later.
